// File: rtl/res_stream_packer.sv
// Captures result-memory reads after a fixed latency, buffers them in a FWFT FIFO
// and streams them out as valid/ready with a frame-end marker.
// Optional feature: define RES_STREAM_PACKER_OVF_CNT_EN to add the saturating ovf_cnt_out drop counter.
module res_stream_packer #(
    parameter int          D_WIDTH    = 64,
    parameter int          ADDR_WIDTH = 32,
    parameter int          RD_LATENCY = 1,
    parameter int unsigned RES_WORDS  = 64,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  res_rd_en_in,
    input  logic [ADDR_WIDTH-1:0] res_rd_addr_in,
    input  logic [D_WIDTH-1:0]    res_rd_data_in,
    output logic [D_WIDTH-1:0]    m_data_out,
    output logic                  m_valid_out,
    output logic                  m_last_out,
    input  logic                  m_ready_in,
    output logic                  frame_done_out,
    output logic                  busy_out,
    output logic                  ovf_out
`ifdef RES_STREAM_PACKER_OVF_CNT_EN
    ,
    output logic [15:0]           ovf_cnt_out
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RES_WORDS - 1);
    localparam logic [ADDR_WIDTH:0]   WORDS_EXT = (ADDR_WIDTH + 1)'(RES_WORDS);
    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    logic [RD_LATENCY-1:0] dl_en, dl_last, dl_in_range;
    logic [D_WIDTH-1:0]    mem_data [FIFO_DEPTH];
    logic                  mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count, count_next, last_cnt, last_cnt_next;
    state_t                state;

    logic tap_push, tap_last, full, pop, push_ok, drop, push_last, pop_last;

    // Delay line tracks each strobe until its read data appears on res_rd_data_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_en       <= '0;
            dl_last     <= '0;
            dl_in_range <= '0;
        end else begin
            dl_en[0]       <= res_rd_en_in;
            dl_last[0]     <= (res_rd_addr_in == LAST_ADDR);
            dl_in_range[0] <= ({1'b0, res_rd_addr_in} < WORDS_EXT);
            for (int i = 1; i < RD_LATENCY; i++) begin
                dl_en[i]       <= dl_en[i-1];
                dl_last[i]     <= dl_last[i-1];
                dl_in_range[i] <= dl_in_range[i-1];
            end
        end
    end

    assign tap_push = dl_en[RD_LATENCY-1] & dl_in_range[RD_LATENCY-1];
    assign tap_last = dl_last[RD_LATENCY-1];

    assign full        = (count == FULL_CNT);
    assign m_valid_out = (count != '0);
    assign m_data_out  = m_valid_out ? mem_data[rd_ptr] : '0;
    assign m_last_out  = m_valid_out & mem_last[rd_ptr];
    assign busy_out    = (state != IDLE);

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign pop       = m_valid_out & m_ready_in;
    assign push_ok   = tap_push & (~full | pop);
    assign drop      = tap_push & full & ~pop;
    assign push_last = push_ok & tap_last;
    assign pop_last  = pop & m_last_out;

    always_comb begin
        count_next    = count + CNT_W'(push_ok) - CNT_W'(pop);
        last_cnt_next = last_cnt + CNT_W'(push_last) - CNT_W'(pop_last);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= res_rd_data_in;
            mem_last[wr_ptr] <= tap_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_cnt <= '0;
            ovf_out  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            last_cnt <= last_cnt_next;
            if (drop) ovf_out <= 1'b1;
        end
    end

`ifdef RES_STREAM_PACKER_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_out <= '0;
        end else if (drop && ovf_cnt_out != 16'hFFFF) begin
            ovf_cnt_out <= ovf_cnt_out + 16'd1;
        end
    end
`endif

    // Frame tracking; last_cnt keeps overlapping frames straight when more than one marker is buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            frame_done_out <= 1'b0;
        end else begin
            frame_done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (push_ok) state <= push_last ? DRAIN : ACTIVE;
                end
                ACTIVE: begin
                    if (push_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop_last) begin
                        frame_done_out <= 1'b1;
                        if (last_cnt_next != '0)   state <= DRAIN;
                        else if (count_next != '0) state <= ACTIVE;
                        else                       state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_res_stream_packer.sv
// Randomized self-checking bench for res_stream_packer against a queue-based reference model.
// Connects ovf_cnt_out when RES_STREAM_PACKER_OVF_CNT_EN is defined.
module tb_res_stream_packer;

    localparam int DW    = 64;
    localparam int AW    = 32;
    localparam int LAT   = 3;
    localparam int WORDS = 8;
    localparam int DEPTH = 4;
    localparam logic [31:0] LAST_ADDR = 32'(WORDS - 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          res_rd_en_in;
    logic [AW-1:0] res_rd_addr_in;
    logic [DW-1:0] res_rd_data_in;
    logic [DW-1:0] m_data_out;
    logic          m_valid_out;
    logic          m_last_out;
    logic          m_ready_in;
    logic          frame_done_out;
    logic          busy_out;
    logic          ovf_out;
`ifdef RES_STREAM_PACKER_OVF_CNT_EN
    logic [15:0]   ovf_cnt_out;
`endif

    res_stream_packer #(
        .D_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT),
        .RES_WORDS(WORDS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .res_rd_en_in(res_rd_en_in), .res_rd_addr_in(res_rd_addr_in),
        .res_rd_data_in(res_rd_data_in),
        .m_data_out(m_data_out), .m_valid_out(m_valid_out), .m_last_out(m_last_out),
        .m_ready_in(m_ready_in), .frame_done_out(frame_done_out),
        .busy_out(busy_out), .ovf_out(ovf_out)
`ifdef RES_STREAM_PACKER_OVF_CNT_EN
        , .ovf_cnt_out(ovf_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } word_t;

    int          vectors = 0;
    int          miscompares = 0;
    word_t       expQ[$];
    logic        expFd, expBusy, expOvf;
    int          expDrops;
    logic        hEn   [LAT+1];
    logic [31:0] hAddr [LAT+1];
    logic [63:0] hData [LAT+1];
    logic [31:0] seed;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("valid", 64'(m_valid_out), 64'(expQ.size() != 0));
        if (expQ.size() != 0) begin
            checkOutput("data", m_data_out, expQ[0].data);
            checkOutput("last", 64'(m_last_out), 64'(expQ[0].last));
        end
        checkOutput("frame_done", 64'(frame_done_out), 64'(expFd));
        checkOutput("busy", 64'(busy_out), 64'(expBusy));
        checkOutput("ovf", 64'(ovf_out), 64'(expOvf));
`ifdef RES_STREAM_PACKER_OVF_CNT_EN
        checkOutput("ovf_cnt", 64'(ovf_cnt_out), 64'((expDrops > 65535) ? 65535 : expDrops));
`endif
    endtask

    // Called at a falling edge: check current outputs, drive the next cycle, advance the model.
    task automatic applyStimulus(input logic en, input logic [31:0] addr, input logic ready);
        logic  doPop, fdNext, pushed;
        word_t w;
        checkAll();
        res_rd_en_in   = en;
        res_rd_addr_in = addr;
        m_ready_in     = ready;
        for (int i = LAT; i > 0; i--) begin
            hEn[i]   = hEn[i-1];
            hAddr[i] = hAddr[i-1];
            hData[i] = hData[i-1];
        end
        hEn[0]   = en;
        hAddr[0] = addr;
        hData[0] = {seed, addr};
        res_rd_data_in = hEn[LAT] ? hData[LAT] : {$urandom, $urandom};

        doPop  = (expQ.size() != 0) && ready;
        fdNext = doPop && expQ[0].last;
        if (doPop) void'(expQ.pop_front());
        pushed = 1'b0;
        if (hEn[LAT] && hAddr[LAT] < 32'(WORDS)) begin
            if (expQ.size() < DEPTH) begin
                w.data = hData[LAT];
                w.last = (hAddr[LAT] == LAST_ADDR);
                expQ.push_back(w);
                pushed = 1'b1;
            end else begin
                expOvf = 1'b1;
                expDrops++;
            end
        end
        expBusy = fdNext ? (expQ.size() != 0) : (expBusy || pushed);
        expFd   = fdNext;
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst_n          = 1'b0;
        res_rd_en_in   = 1'b0;
        res_rd_addr_in = '0;
        res_rd_data_in = '0;
        m_ready_in     = 1'b0;
        #1;
        checkOutput("rst_valid", 64'(m_valid_out), 64'd0);
        checkOutput("rst_busy", 64'(busy_out), 64'd0);
        checkOutput("rst_ovf", 64'(ovf_out), 64'd0);
        checkOutput("rst_frame_done", 64'(frame_done_out), 64'd0);
        expQ.delete();
        expFd    = 1'b0;
        expBusy  = 1'b0;
        expOvf   = 1'b0;
        expDrops = 0;
        for (int i = 0; i <= LAT; i++) begin
            hEn[i]   = 1'b0;
            hAddr[i] = '0;
            hData[i] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        seed = $urandom;
        applyReset();

        // Clean frame with the consumer always ready, then out-of-range reads.
        for (int a = 0; a < WORDS + 6; a++) applyStimulus(1'b1, 32'(a), 1'b1);
        repeat (LAT + 6) applyStimulus(1'b0, '0, 1'b1);

        // Backpressure overflow, then a full FIFO popped and pushed in the same cycle.
        seed = $urandom;
        for (int a = 0; a < WORDS; a++) applyStimulus(1'b1, 32'(a), 1'b0);
        repeat (LAT + 2) applyStimulus(1'b0, '0, 1'b0);
        seed = $urandom;
        for (int a = 0; a < WORDS; a++) applyStimulus(1'b1, 32'(a), (a >= LAT));
        repeat (LAT + 12) applyStimulus(1'b0, '0, 1'b1);

        // Random gaps and 50% ready over several frames.
        for (int f = 0; f < 8; f++) begin
            int a = 0;
            seed = $urandom;
            while (a < WORDS + 2) begin
                logic en = ($urandom_range(0, 3) != 0);
                applyStimulus(en, 32'(a), 1'($urandom_range(0, 1)));
                if (en) a++;
            end
        end
        repeat (40) applyStimulus(1'b0, '0, 1'($urandom_range(0, 1)));
        repeat (80) applyStimulus(1'($urandom_range(0, 1)), 32'($urandom_range(0, WORDS + 3)),
                                  1'($urandom_range(0, 1)));
        repeat (LAT + 12) applyStimulus(1'b0, '0, 1'b1);

        // Reset mid-frame with words buffered and in flight, then a fresh frame.
        seed = $urandom;
        for (int a = 0; a < 6; a++) applyStimulus(1'b1, 32'(a), 1'b0);
        applyReset();
        seed = $urandom;
        for (int a = 0; a < WORDS; a++) applyStimulus(1'b1, 32'(a), 1'($urandom_range(0, 1)));
        repeat (LAT + 20) applyStimulus(1'b0, '0, 1'b1);
        checkAll();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
